// File: rtl/serial_byte_transmitter.sv
// LSB-first parallel-to-serial shifter: one bit of `in` per enabled clock,
// then `done` stays high and `out` returns to 0 until the next reset.
module serial_byte_transmitter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic             out,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam int PAD_W = (1 << IDX_W) - WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH);

    logic [IDX_W-1:0]       idx_reg;
    logic [IDX_W-1:0]       idx_next;
    logic                   out_reg;
    logic                   out_next;
    logic [(1<<IDX_W)-1:0]  in_padded;

    // Pad to a power of two so the counter indexes the word at its natural width.
    assign in_padded = {{PAD_W{1'b0}}, in};
    assign done      = (idx_reg == LAST_IDX);
    assign out       = out_reg;

    always_comb begin
        idx_next = idx_reg;
        out_next = out_reg;
        if (enable) begin
            if (!done) begin
                out_next = in_padded[idx_reg];
                idx_next = idx_reg + IDX_W'(1);
            end else begin
                out_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg <= '0;
            out_reg <= 1'b0;
        end else begin
            idx_reg <= idx_next;
            out_reg <= out_next;
        end
    end

endmodule

// File: tb/tb_serial_byte_transmitter.sv
// Directed bench for serial_byte_transmitter: a 32-bit and an 8-bit instance
// sharing one clock, checked with immediate assertions after each edge.
module tb_serial_byte_transmitter;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [31:0] in;
    logic        out, done;
    logic        reset8, enable8;
    logic [7:0]  in8;
    logic        out8, done8;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] word;
    logic [7:0]  word8;

    always #5 clk = ~clk;

    serial_byte_transmitter #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .enable(enable), .in(in), .out(out), .done(done)
    );

    serial_byte_transmitter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .enable(enable8), .in(in8), .out(out8), .done(done8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; in = '0;
        reset8 = 1'b1; enable8 = 1'b0; in8 = '0;

        // Reset, then idle with enable low
        tick();
        reset = 1'b0; reset8 = 1'b0;
        check("reset_out", out, 1'b0);
        check("reset_done", done, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_out", out, 1'b0);
            check("idle_done", done, 1'b0);
        end
        $display("idle after reset checked");

        // Uninterrupted 32-bit word
        word = 32'h000FAF01;
        in = word; enable = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tick();
            check("faf01_out", out, word[k]);
            check("faf01_done", done, (k == 31));
        end
        $display("word 000FAF01 sent");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_done_out", out, 1'b0);
            check("post_done_done", done, 1'b1);
        end
        $display("post-done edges checked");

        // Pause in the middle of a word
        reset = 1'b1; enable = 1'b0;
        tick();
        reset = 1'b0;
        check("rst2_done", done, 1'b0);
        word = 32'hA5A5A5A5;
        in = word; enable = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("a5_out", out, word[k]);
            check("a5_done", done, 1'b0);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_out", out, word[8]);
            check("pause_done", done, 1'b0);
        end
        enable = 1'b1;
        for (int k = 9; k < 32; k++) begin
            tick();
            check("a5_resume_out", out, word[k]);
            check("a5_resume_done", done, (k == 31));
        end
        $display("word A5A5A5A5 with pause sent");

        // Reset mid-word with enable high on the reset edge
        reset = 1'b1; enable = 1'b0;
        tick();
        reset = 1'b0;
        word = 32'hFFFFFFFF;
        in = word; enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("ff_out", out, word[k]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out", out, 1'b0);
        check("midrst_done", done, 1'b0);
        for (int k = 0; k < 32; k++) begin
            tick();
            check("ff_again_out", out, word[k]);
            check("ff_again_done", done, (k == 31));
        end
        $display("mid-word reset and full resend checked");

        // WIDTH=8 instance
        enable = 1'b0;
        check("w8_idle_out", out8, 1'b0);
        check("w8_idle_done", done8, 1'b0);
        word8 = 8'h81;
        in8 = word8; enable8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("w8_out", out8, word8[k]);
            check("w8_done", done8, (k == 7));
        end
        tick();
        check("w8_post_out", out8, 1'b0);
        check("w8_post_done", done8, 1'b1);
        reset8 = 1'b1;
        tick();
        reset8 = 1'b0; enable8 = 1'b0;
        check("w8_rst_done", done8, 1'b0);
        $display("width 8 word 81 sent");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
